// File: rtl/signed_restoring_divider_pkg.sv
// Shared types and default widths for the sequential signed divider.
package divider_pkg;

    localparam int DEF_DVD_W = 16;
    localparam int DEF_DVS_W = 8;
    localparam int CNT_W     = $clog2(DEF_DVD_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/signed_restoring_divider_if.sv
// Operand/result handshake bundle for the signed divider.
interface signed_restoring_divider_if
    import divider_pkg::*;
#(
    parameter int DVD_W = DEF_DVD_W,
    parameter int DVS_W = DEF_DVS_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DVD_W-1:0] dividend;
    logic signed [DVS_W-1:0] divisor;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DVD_W-1:0] quotient;
    logic signed [DVS_W-1:0] remainder;
    logic                    div_by_zero;
    logic                    overflow;

    // Producer/consumer side of the divider.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    // The divider itself.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_restoring_divider_twos_abs.sv
// Combinational two's-complement magnitude and sign extraction.
module twos_abs #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] x,
    output logic        [W-1:0] mag,
    output logic                sign
);
    assign sign = x[W-1];
    // Most-negative input maps to 2^(W-1), which is exact as an unsigned value.
    assign mag  = sign ? (~$unsigned(x) + W'(1)) : $unsigned(x);
endmodule

// File: rtl/signed_restoring_divider.sv
// Sequential signed divider: magnitude restoring division, one quotient bit per clock.
module signed_restoring_divider
    import divider_pkg::*;
#(
    parameter int DVD_W = DEF_DVD_W,
    parameter int DVS_W = DEF_DVS_W
) (
    input  logic clk,
    input  logic rst,
    signed_restoring_divider_if.slave bus
);
    localparam int               STEP_W    = $clog2(DVD_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DVD_W - 1);
    localparam logic [DVD_W-1:0]  DVD_MIN   = {1'b1, {(DVD_W-1){1'b0}}};

    function automatic logic [DVD_W-1:0] neg_dvd(input logic [DVD_W-1:0] v);
        return ~v + DVD_W'(1);
    endfunction

    function automatic logic [DVS_W-1:0] neg_dvs(input logic [DVS_W-1:0] v);
        return ~v + DVS_W'(1);
    endfunction

    state_t             state;
    logic [DVD_W-1:0]   dvd_mag_c;
    logic               dvd_sign_c;
    logic [DVS_W-1:0]   dvs_mag_c;
    logic               dvs_sign_c;

    // work starts as the dividend magnitude and is shifted out MSB-first while
    // quotient bits are shifted in at the LSB, so it ends holding the quotient.
    logic [DVD_W-1:0]   work;
    logic [DVS_W:0]     part_rem;
    logic [DVS_W-1:0]   dvs_mag;
    logic               sign_dvd;
    logic               sign_dvs;
    logic [STEP_W-1:0]  step;
    logic               dbz_pend;
    logic               ovf_pend;

    logic               in_ready_r;
    logic               out_valid_r;
    logic [DVD_W-1:0]   quo_r;
    logic [DVS_W-1:0]   rem_r;
    logic               dbz_r;
    logic               ovf_r;

    logic [DVS_W:0]     rem_shift;
    logic [DVS_W:0]     rem_next;
    logic               take;

    twos_abs #(.W(DVD_W)) u_abs_dvd (.x(bus.dividend), .mag(dvd_mag_c), .sign(dvd_sign_c));
    twos_abs #(.W(DVS_W)) u_abs_dvs (.x(bus.divisor),  .mag(dvs_mag_c), .sign(dvs_sign_c));

    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign bus.in_ready    = in_ready_r & ~rst;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = $signed(quo_r);
    assign bus.remainder   = $signed(rem_r);
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {part_rem[DVS_W-1:0], work[DVD_W-1]};
        take      = (rem_shift >= {1'b0, dvs_mag});
        rem_next  = take ? (rem_shift - {1'b0, dvs_mag}) : rem_shift;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quo_r       <= '0;
            rem_r       <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            step        <= '0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        dbz_r      <= 1'b0;
                        ovf_r      <= 1'b0;
                        sign_dvd   <= dvd_sign_c;
                        sign_dvs   <= dvs_sign_c;
                        dvs_mag    <= dvs_mag_c;
                        part_rem   <= '0;
                        step       <= '0;
                        dbz_pend   <= (dvs_mag_c == '0);
                        ovf_pend   <= ($unsigned(bus.dividend) == DVD_MIN) && (bus.divisor == '1);
                        // A zero divisor skips CALC with a zeroed result; SIGN then
                        // publishes it one cycle after acceptance.
                        if (dvs_mag_c == '0) begin
                            work  <= '0;
                            state <= SIGN;
                        end else begin
                            work  <= dvd_mag_c;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    part_rem <= rem_next;
                    work     <= {work[DVD_W-2:0], take};
                    step     <= step + STEP_W'(1);
                    if (step == LAST_STEP) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Overflow case needs no special handling: 2^(DVD_W-1) unnegated
                    // already reads as the most-negative value.
                    quo_r       <= (sign_dvd ^ sign_dvs) ? neg_dvd(work) : work;
                    rem_r       <= sign_dvd ? neg_dvs(part_rem[DVS_W-1:0]) : part_rem[DVS_W-1:0];
                    dbz_r       <= dbz_pend;
                    ovf_r       <= ovf_pend;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_restoring_divider.sv
// Self-checking bench for signed_restoring_divider against an integer-arithmetic model.
module tb_signed_restoring_divider;
    localparam int DW = 16;
    localparam int SW = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    signed_restoring_divider_if #(.DVD_W(DW), .DVS_W(SW)) bus ();

    signed_restoring_divider #(.DVD_W(DW), .DVS_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: truncating integer division, with the two special cases.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = 0; r = 0; dz = 1'b1;
        end else if (a == -32768 && b == -1) begin
            q = -32768; r = 0; ov = 1'b1;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, wait for the result, then complete the output handshake.
    task automatic run_op(input logic signed [DW-1:0] a, input logic signed [SW-1:0] b,
                          input int ready_delay,
                          output logic signed [DW-1:0] q, output logic signed [SW-1:0] r,
                          output logic dz, output logic ov, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = SW'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
        ov = bus.overflow;
        for (int i = 0; i < ready_delay; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        n_checks++;
        if ({bus.out_valid, bus.div_by_zero, bus.overflow} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000",
                               {bus.out_valid, bus.div_by_zero, bus.overflow});
        end
        n_checks++;
        if (bus.quotient !== 16'sd0 || bus.remainder !== 8'sd0) begin
            n_fail++; $display("FAIL reset_result: got q=%0d r=%0d expected 0 0", bus.quotient, bus.remainder);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic signed [DW-1:0] q; logic signed [SW-1:0] r; logic dz, ov; int lat;
        run_op(16'sd100, 8'sd7, 0, q, r, dz, ov, lat);
        n_checks++;
        if (q !== 16'sd14 || r !== 8'sd2) begin
            n_fail++; $display("FAIL basic_100_7: got q=%0d r=%0d expected 14 2", q, r);
        end
        n_checks++;
        if ({dz, ov} !== 2'b00) begin
            n_fail++; $display("FAIL basic_flags: got %b expected 00", {dz, ov});
        end
        n_checks++;
        if (lat !== 17) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 17", lat);
        end
    endtask

    task automatic test_signs();
        int ta [3] = '{-100, 100, -100};
        int tb [3] = '{7, -7, -7};
        int eq [3] = '{-14, -14, 14};
        int er [3] = '{-2, 2, -2};
        logic signed [DW-1:0] q; logic signed [SW-1:0] r; logic dz, ov; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(DW'(ta[i]), SW'(tb[i]), i, q, r, dz, ov, lat);
            n_checks++;
            if (q !== DW'(eq[i]) || r !== SW'(er[i])) begin
                n_fail++; $display("FAIL signs_%0d_%0d: got q=%0d r=%0d expected %0d %0d",
                                   ta[i], tb[i], q, r, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [DW-1:0] q; logic signed [SW-1:0] r; logic dz, ov; int lat;
        run_op(-16'sd32768, -8'sd1, 0, q, r, dz, ov, lat);
        n_checks++;
        if (q !== 16'h8000 || r !== 8'sd0 || ov !== 1'b1 || dz !== 1'b0) begin
            n_fail++; $display("FAIL overflow_min_m1: got q=%h r=%0d ov=%b dz=%b expected 8000 0 1 0", q, r, ov, dz);
        end
        run_op(-16'sd32768, -8'sd128, 0, q, r, dz, ov, lat);
        n_checks++;
        if (q !== 16'sd256 || r !== 8'sd0 || ov !== 1'b0) begin
            n_fail++; $display("FAIL range_min_m128: got q=%0d r=%0d ov=%b expected 256 0 0", q, r, ov);
        end
    endtask

    task automatic test_div_zero();
        logic signed [DW-1:0] q; logic signed [SW-1:0] r; logic dz, ov; int lat;
        run_op(16'sd5, 8'sd0, 0, q, r, dz, ov, lat);
        n_checks++;
        if (dz !== 1'b1 || ov !== 1'b0 || q !== 16'sd0 || r !== 8'sd0) begin
            n_fail++; $display("FAIL div_zero: got dz=%b ov=%b q=%0d r=%0d expected 1 0 0 0", dz, ov, q, r);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL div_zero_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int busy_bad;
        busy_bad = 0;
        bus.in_valid = 1'b1;
        bus.dividend = 16'sd1000;
        bus.divisor  = 8'sd3;
        tick();
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            bus.dividend = DW'($urandom);
            bus.divisor  = SW'($urandom);
            if (bus.in_ready !== 1'b0) busy_bad++;
            tick();
            lat++;
        end
        n_checks++;
        if (busy_bad != 0 || lat !== 17) begin
            n_fail++; $display("FAIL bp_busy: in_ready high %0d times, latency %0d expected 0 and 17", busy_bad, lat);
        end
        n_checks++;
        if (bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL bp_flags_cleared: got dz=%b ov=%b expected 0 0", bus.div_by_zero, bus.overflow);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.quotient !== 16'sd333 || bus.remainder !== 8'sd1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got q=%0d r=%0d ov=%b rdy=%b expected 333 1 1 0",
                                   i, bus.quotient, bus.remainder, bus.out_valid, bus.in_ready);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int qa, ra, qb, rb, lat;
        logic dza, ova, dzb, ovb;
        logic signed [DW-1:0] q;
        logic signed [SW-1:0] r;
        model(1234, -11, qa, ra, dza, ova);
        model(-32767, 127, qb, rb, dzb, ovb);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 16'sd1234;
        bus.divisor   = -8'sd11;
        tick();
        bus.dividend  = -16'sd32767;
        bus.divisor   = 8'sd127;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        q = bus.quotient; r = bus.remainder;
        n_checks++;
        if (q !== DW'(qa) || r !== SW'(ra) || lat !== 17) begin
            n_fail++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d expected %0d %0d 17", q, r, lat, qa, ra);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_turnaround: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_accept: got in_ready=%b expected 0", bus.in_ready);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        q = bus.quotient; r = bus.remainder;
        n_checks++;
        if (q !== DW'(qb) || r !== SW'(rb) || lat !== 17) begin
            n_fail++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d expected %0d %0d 17", q, r, lat, qb, rb);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        logic signed [DW-1:0] q; logic signed [SW-1:0] r; logic dz, ov; int lat;
        int rises;
        bus.in_valid = 1'b1;
        bus.dividend = 16'sd500;
        bus.divisor  = 8'sd3;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) rises++;
        end
        n_checks++;
        if (rises != 0) begin
            n_fail++; $display("FAIL rst_mid_no_valid: got %0d valid cycles expected 0", rises);
        end
        run_op(16'sd30000, 8'sd120, 0, q, r, dz, ov, lat);
        n_checks++;
        if (q !== 16'sd250 || r !== 8'sd0 || lat !== 17) begin
            n_fail++; $display("FAIL rst_mid_next_op: got q=%0d r=%0d lat=%0d expected 250 0 17", q, r, lat);
        end
    endtask

    task automatic test_random();
        logic signed [DW-1:0] a, q;
        logic signed [SW-1:0] b, r;
        logic dz, ov, edz, eov;
        int eq, er, lat, elat;
        for (int i = 0; i < 1000; i++) begin
            a = DW'($urandom);
            b = SW'($urandom);
            if ($urandom_range(0, 9) == 0) a = -16'sd32768;
            case ($urandom_range(0, 11))
                0: b = 8'sd0;
                1: b = -8'sd1;
                2: b = -8'sd128;
                3: b = 8'sd1;
                default: ;
            endcase
            model(int'(a), int'(b), eq, er, edz, eov);
            elat = (b == 8'sd0) ? 1 : 17;
            run_op(a, b, int'($urandom_range(0, 2)), q, r, dz, ov, lat);
            n_checks++;
            if (q !== DW'(eq) || r !== SW'(er) || dz !== edz || ov !== eov || lat !== elat) begin
                n_fail++;
                $display("FAIL random_%0d %0d/%0d: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected %0d %0d %b %b %0d",
                         i, a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_restoring_divider.md
# signed_restoring_divider

Sequential signed divider, the inverse of the team's combinational signed Vedic multiplier. It takes a signed dividend and a signed divisor through a valid/ready handshake and converts both to magnitudes with the same two's-complement rule the multiplier uses. It then runs one restoring-division step per clock and returns a sign-corrected quotient and remainder. It sits beside the multiplier in the arithmetic datapath and checks multiplier results (`(a*b)/b == a`).

## Interface
- `DVD_W`, default 16: dividend and quotient width, signed two's complement.
- `DVS_W`, default 8: divisor and remainder width, signed two's complement.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `dividend`  in  `DVD_W`  signed dividend.
- `divisor`  in  `DVS_W`  signed divisor.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes result.
- `quotient`  out  `DVD_W`  signed quotient, truncated toward zero.
- `remainder`  out  `DVS_W`  signed remainder; its sign follows the dividend.
- `div_by_zero`  out  1  divisor was 0.
- `overflow`  out  1  quotient not representable (most-negative dividend divided by -1).

## Operation
**States:** IDLE, CALC, SIGN, DONE.

**IDLE**
- `in_ready`=1.
- On `in_valid && in_ready`, register the magnitudes (`x[MSB] ? ~x+1 : x`, unsigned) and the two sign bits.
- If the divisor is 0, go to DONE with `div_by_zero`=1, `quotient`=0, `remainder`=0.
- Otherwise go to CALC with `count`=0 and partial remainder `R`=0.

**CALC**
- Each cycle: `R = {R, dvd_mag[MSB-count]}`, with `R` being `DVS_W+1` bits.
- If `R >= dvs_mag`, then `R -= dvs_mag` and quotient bit = 1; otherwise quotient bit = 0.
- Runs `DVD_W` cycles, then goes to SIGN.

**SIGN**
- Quotient is negated if `sign_dvd ^ sign_dvs`.
- Remainder is negated if `sign_dvd`.
- `overflow`=1 when the dividend is the most-negative value and the divisor is -1. The quotient then wraps to the most-negative value (16'h8000 at defaults).
- Go to DONE.

**DONE**
- `out_valid`=1. All outputs are held stable until `out_valid && out_ready`, then go to IDLE.

**Width rules**
- Remainder magnitude is below `|divisor|` ≤ 2^(DVS_W-1), so it always fits in `DVS_W` signed bits.
- Quotient magnitude is at most 2^(DVD_W-1); only the overflow case exceeds the signed range.

## Timing
**Reset values:** `in_ready`=0 while `rst` is high and 1 in the first cycle after; `out_valid`=0; `quotient`=0; `remainder`=0; `div_by_zero`=0; `overflow`=0; state=IDLE.

**Latency** (acceptance edge = E0):
- CALC covers edges E1..E16.
- SIGN executes at E17; `out_valid` is high from E17, i.e. `DVD_W`+1 = 17 cycles.
- Divide by zero: `out_valid` is high from E1.

**Handshake rules**
- `in_ready` is asserted only in IDLE, so there is one operation in flight.
- Inputs are ignored outside IDLE.
- Back-to-back throughput: one result per `DVD_W`+3 cycles. `in_ready` rises the cycle after the output handshake.
- `out_ready` may be high before `out_valid`; the transfer happens on the first edge where both are high.
- Operands are sampled only at the acceptance edge. Changes afterwards have no effect.

**Boundary conditions**
- `rst` mid-CALC, SIGN or DONE: returns to IDLE next edge, result discarded, no `out_valid`.
- Flags are cleared on each new acceptance.

## Structure
- Package `divider_pkg` holds:
  - state enum (IDLE, CALC, SIGN, DONE);
  - `DVD_W`/`DVS_W` defaults;
  - `CNT_W` = $clog2(`DVD_W`+1).
- One sub-module, `twos_abs`: combinational parameterised magnitude plus sign extract, instantiated twice (dividend, divisor). Negation in SIGN reuses the same `~x+1` expression.
- The restoring step stays inline in the FSM.

## Test plan
- 100 / 7 → `quotient`=14, `remainder`=2, flags 0, `out_valid` exactly 17 cycles after acceptance.
- Signs:
  - -100 / 7 → -14, -2
  - 100 / -7 → -14, 2
  - -100 / -7 → 14, -2
- Overflow and range limits:
  - -32768 / -1 → `quotient`=16'h8000, `remainder`=0, `overflow`=1.
  - -32768 / -128 → 256, 0, `overflow`=0.
- Divide by zero: 5 / 0 → `div_by_zero`=1, `quotient`=0, `remainder`=0, `out_valid` 1 cycle after acceptance.
- Backpressure: 1000 / 3 with `out_ready` low 5 cycles after `out_valid` → 333 and 1 held stable; `in_ready` stays 0; operands driven during the busy period are ignored.
- Reset and randomised check:
  - `rst` pulsed at CALC cycle 8 → `out_valid` never rises, `in_ready`=1 next cycle, the following 30000 / 120 yields 250, 0.
  - 1000 random pairs checked against `$signed` `/` and `%`.
